iq_to_float: RTL
================

IQ_TO_FLOAT -- requirements
Module: iq_to_float

Interface
REQ-001 clk  input  1  single clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 i_tdata  input  32  complex sample: I in [31:16], Q in [15:0], two's complement.
REQ-004 i_tlast  input  1  end-of-packet marker, carried alongside its sample.
REQ-005 i_tvalid  input  1  input sample valid.
REQ-006 i_tready  output  1  block accepts a sample when i_tvalid & i_tready.
REQ-007 o_tdata  output  64  IEEE-754 single: I float in [63:32], Q float in [31:0].
REQ-008 o_tlast  output  1  i_tlast of the sample in o_tdata.
REQ-009 o_tvalid  output  1  output sample valid.
REQ-010 o_tready  input  1  downstream accepts when o_tvalid & o_tready.

Function
REQ-011 The block SHALL convert each 16-bit lane independently to an exact single-precision float; no rounding is needed because every 16-bit value is exactly representable.
REQ-012 The pipeline SHALL have three register stages: S1 sign and magnitude; S2 leading-zero count and exponent; S3 mantissa normalisation and packing into o_tdata/o_tlast.
REQ-013 Pipeline enable SHALL be en = o_tready | ~o_tvalid; i_tready SHALL equal en, forced to 0 while reset is high.
REQ-014 When en=1, every stage SHALL advance one position and its valid bit SHALL take the previous stage's valid bit (S1 takes i_tvalid & i_tready); when en=0, all stages SHALL hold.
REQ-015 Latency SHALL be exactly 3 cycles from acceptance to o_tvalid while o_tready=1; sustained throughput SHALL be 1 sample per cycle.
REQ-016 Bubbles (valid=0 entries) SHALL be squeezed out: when o_tvalid=0, en=1 regardless of o_tready.
REQ-017 o_tdata and o_tlast SHALL stay stable while o_tvalid=1 and o_tready=0.
REQ-018 Lane value 0 SHALL produce +0.0 (0x00000000); no negative zero SHALL be produced.
REQ-019 Lane value -32768 (0x8000) SHALL use magnitude 32768 (17-bit internal magnitude), never a wrapped value.
REQ-020 For a nonzero lane: sign = bit 15; with p the leading-one position of |x| (0..15), exponent = 127 + p - K and mantissa = bits below the leading one, left-justified into 23 bits and zero-filled. K is defined in REQ-025.
REQ-021 No denormal, infinity or NaN encodings SHALL ever be produced.
REQ-022 o_tlast SHALL travel through the pipeline with its sample and be valid only when o_tvalid=1.

Reset
REQ-023 While reset=1: all stage valid bits, o_tvalid, o_tlast and o_tdata SHALL be 0 on the next edge, and i_tready SHALL be 0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight samples; no partial sample SHALL appear after reset deasserts, and the first sample accepted after reset SHALL emerge 3 cycles later.

Configuration
REQ-025 With macro IQ_TO_FLOAT_Q15_EN defined, lanes SHALL be treated as Q15 fractions (K=15, so 0x4000 gives 0.5); undefined, lanes SHALL be treated as integers (K=0). Only the exponent offset SHALL differ.

Verification
REQ-026 Integer build, o_tready=1, i_tdata=0x7FFF_8000 -> after 3 cycles o_tdata=0x46FFFE00_C7000000.
REQ-027 Q15 build, i_tdata=0x4000_8000 then 0x0001_0000 -> o_tdata=0x3F000000_BF800000, then 0x38000000_00000000 on the following cycle.
REQ-028 Random 1000 samples with random i_tvalid and o_tready gaps -> output sequence equals the software model (with i_tlast), with no loss, duplication or reordering, and o_tdata held stable during stalls.
REQ-029 Fill the pipeline with o_tready=0 -> i_tready drops after 3 accepted samples; raising o_tready drains 3 samples on 3 consecutive cycles.
REQ-030 Assert reset for 1 cycle with 2 samples in flight -> o_tvalid=0 next cycle and neither sample is ever output.
REQ-031 Integer build, i_tdata=0x0001_FFFF -> o_tdata=0x3F800000_BF800000.

Source files
------------

// File: rtl/iq_to_float.sv
// iq_to_float: converts a packed 16-bit I/Q sample into two IEEE-754 singles through a 3-stage pipeline.
// Optional macro IQ_TO_FLOAT_Q15_EN treats each lane as a Q15 fraction instead of an integer.
module iq_to_float (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

`ifdef IQ_TO_FLOAT_Q15_EN
  localparam logic [7:0] EXP_BIAS = 8'd112;
`else
  localparam logic [7:0] EXP_BIAS = 8'd127;
`endif

  // 17 bits so that -32768 maps to +32768 instead of wrapping.
  function automatic logic [16:0] lane_mag(input logic [15:0] x);
    logic [16:0] xs;
    xs = {x[15], x};
    if (x[15]) lane_mag = 17'd0 - xs;
    else       lane_mag = xs;
  endfunction

  function automatic logic [3:0] lead_one(input logic [15:0] mag);
    lead_one = 4'd0;
    for (int b = 0; b < 16; b++) begin
      if (mag[b]) lead_one = 4'(b);
    end
  endfunction

  function automatic logic [22:0] norm_mant(input logic [15:0] mag, input logic [3:0] pos);
    logic [15:0] sh;
    sh = mag << (4'd15 - pos);
    norm_mant = {sh[14:0], 8'd0};
  endfunction

  logic        en_s;
  logic        s1_valid_r;
  logic        s1_last_r;
  logic [1:0]  s1_sign_r;
  logic [16:0] s1_mag_r [2];
  logic        s2_valid_r;
  logic        s2_last_r;
  logic [1:0]  s2_sign_r;
  logic [1:0]  s2_zero_r;
  logic [15:0] s2_mag_r [2];
  logic [3:0]  s2_pos_r [2];
  logic [7:0]  s2_exp_r [2];

  assign en_s     = o_tready | ~o_tvalid;
  assign i_tready = en_s & ~reset;

  // Stage 1: split each lane into sign and magnitude.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sign_r  <= 2'b00;
      for (int l = 0; l < 2; l++) s1_mag_r[l] <= 17'd0;
    end else if (en_s) begin
      s1_valid_r <= i_tvalid;
      s1_last_r  <= i_tvalid & i_tlast;
      for (int l = 0; l < 2; l++) begin
        s1_sign_r[l] <= i_tdata[16*l + 15];
        s1_mag_r[l]  <= lane_mag(i_tdata[16*l +: 16]);
      end
    end
  end

  // Stage 2: leading-one position and biased exponent.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_sign_r  <= 2'b00;
      s2_zero_r  <= 2'b00;
      for (int l = 0; l < 2; l++) begin
        s2_mag_r[l] <= 16'd0;
        s2_pos_r[l] <= 4'd0;
        s2_exp_r[l] <= 8'd0;
      end
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_sign_r  <= s1_sign_r;
      for (int l = 0; l < 2; l++) begin
        s2_zero_r[l] <= (s1_mag_r[l] == 17'd0);
        s2_mag_r[l]  <= s1_mag_r[l][15:0];
        s2_pos_r[l]  <= lead_one(s1_mag_r[l][15:0]);
        s2_exp_r[l]  <= EXP_BIAS + {4'd0, lead_one(s1_mag_r[l][15:0])};
      end
    end
  end

  // Stage 3: normalise the mantissa and pack both lanes; zero always encodes as +0.0.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= 64'd0;
    end else if (en_s) begin
      o_tvalid <= s2_valid_r;
      o_tlast  <= s2_last_r;
      for (int l = 0; l < 2; l++) begin
        if (s2_zero_r[l]) o_tdata[32*l +: 32] <= 32'd0;
        else o_tdata[32*l +: 32] <= {s2_sign_r[l], s2_exp_r[l], norm_mant(s2_mag_r[l], s2_pos_r[l])};
      end
    end
  end

endmodule
